// File: rtl/user_ahb_pkg.sv
// Shared types and constants for the user-area AHB slave mux.
//   dsel_e  : data-phase target (none / user slave / debug regs / default error slave)
//   state_e : response FSM state
//   nxt_state() : FSM state entered when a transfer to a given target is accepted
package user_ahb_pkg;

  typedef enum logic [1:0] {DS_NONE, DS_SLV, DS_DBG, DS_DEF} dsel_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2, ST_WAIT} state_e;

  // HADDR[23:3] of the debug window (offsets 0xFFFFF8 / 0xFFFFFC)
  localparam logic [20:0] DBG_WIN = 21'h1FFFFF;
  localparam int SLOT_HI = 21;
  localparam int SLOT_LO = 20;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic state_e nxt_state(input dsel_e tgt);
    case (tgt)
      DS_DEF:         return ST_ERR1;
      DS_SLV, DS_DBG: return ST_WAIT;
      default:        return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ahb_wait_watchdog.sv
// Wait-state watchdog: counts consecutive not-ready data-phase cycles.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : a slave/debug data phase is in progress
//   i_rdy          : selected slave HREADYOUT
//   o_expire       : count reached TIMEOUT with ready still low (combinational)
//   o_irq          : one-cycle pulse, the cycle after o_expire
// TIMEOUT = 0 keeps the counter at 0 and never expires.
module ahb_wait_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_rdy,
  output logic o_expire,
  output logic o_irq
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          r_irq;

  // A ready seen in the compare cycle beats the expiry.
  assign o_expire = (TIMEOUT != 0) && i_en && !i_rdy && (r_cnt == LIM);
  assign o_irq    = r_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_irq <= o_expire;
      if (TIMEOUT == 0 || !i_en || i_rdy || o_expire) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/user_ahb_slave_mux.sv
// AHB-Lite decoder / response mux for the user-project slave port.
//   Master side : HSEL, HADDR, HTRANS, HWRITE, HREADY in; HRDATA, HREADYOUT, HRESP out
//   User slaves : S_HSEL out; S_HRDATA (slave i at [32i+31:32i]), S_HREADYOUT, S_HRESP in
//   Debug regs  : D_HSEL out; D_HRDATA, D_HREADYOUT in
//   Watchdog    : timeout_irq pulse, to_slave = last abandoned slot (3 for debug)
// Unmapped, disabled or abandoned slots hit a default slave giving a 2-cycle ERROR.
module user_ahb_slave_mux
  import user_ahb_pkg::*;
#(
  parameter int          NSLV    = 4,
  parameter logic [3:0]  SLV_EN  = 4'b1111,
  parameter int          TIMEOUT = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [NSLV-1:0]      S_HSEL,
  input  logic [32*NSLV-1:0]   S_HRDATA,
  input  logic [NSLV-1:0]      S_HREADYOUT,
  input  logic [NSLV-1:0]      S_HRESP,
  output logic                 D_HSEL,
  input  logic [31:0]          D_HRDATA,
  input  logic                 D_HREADYOUT,
  output logic                 timeout_irq,
  output logic [1:0]           to_slave
);

  state_e      r_state;
  dsel_e       r_dsel;
  logic [1:0]  r_dsel_idx;
  logic        r_abn_vld;
  logic [1:0]  r_abn_idx;
  logic [1:0]  r_to_slave;

  logic [1:0]  w_slot;
  logic        w_is_dbg, w_slot_ok, w_valid;
  dsel_e       w_tgt;
  logic [31:0] w_s_data;
  logic        w_s_rdy, w_s_resp, w_abn_rdy, w_sel_rdy;
  logic        w_wd_en, w_expire;
  logic        w_unused;

  assign w_unused = ^{HWRITE, HTRANS[0], HADDR[31:24], HADDR[2:0]};

  // ---- address-phase decode ----
  assign w_slot   = HADDR[SLOT_HI:SLOT_LO];
  assign w_is_dbg = (HADDR[23:3] == DBG_WIN);
  assign w_valid  = HSEL & HTRANS[1];

  always_comb begin
    w_slot_ok = 1'b0;
    for (int i = 0; i < NSLV; i++)
      if (w_slot == 2'(i) && SLV_EN[i] && !(r_abn_vld && r_abn_idx == 2'(i)))
        w_slot_ok = 1'b1;
  end

  assign w_tgt  = w_is_dbg ? DS_DBG : (w_slot_ok ? DS_SLV : DS_DEF);
  assign D_HSEL = HSEL & w_is_dbg;

  always_comb begin
    S_HSEL = '0;
    for (int i = 0; i < NSLV; i++)
      S_HSEL[i] = HSEL & !w_is_dbg & w_slot_ok & (w_slot == 2'(i));
  end

  // ---- data-phase slave selection ----
  always_comb begin
    w_s_data  = '0;
    w_s_rdy   = 1'b1;
    w_s_resp  = HRESP_OKAY;
    w_abn_rdy = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_dsel_idx == 2'(i)) begin
        w_s_data = S_HRDATA[32*i +: 32];
        w_s_rdy  = S_HREADYOUT[i];
        w_s_resp = S_HRESP[i];
      end
      if (r_abn_idx == 2'(i)) w_abn_rdy = S_HREADYOUT[i];
    end
  end

  assign w_sel_rdy = (r_dsel == DS_DBG) ? D_HREADYOUT : w_s_rdy;
  assign w_wd_en   = (r_state == ST_WAIT) && (r_dsel == DS_SLV || r_dsel == DS_DBG);

  ahb_wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_en     (w_wd_en),
    .i_rdy    (w_sel_rdy),
    .o_expire (w_expire),
    .o_irq    (timeout_irq)
  );

  assign to_slave = r_to_slave;

  // ---- response mux; error states override whatever slave is selected ----
  always_comb begin
    HRDATA    = '0;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (r_state)
      ST_ERR1: begin HREADYOUT = 1'b0; HRESP = HRESP_ERROR; end
      ST_ERR2: begin HREADYOUT = 1'b1; HRESP = HRESP_ERROR; end
      default: begin
        case (r_dsel)
          DS_SLV: begin HRDATA = w_s_data; HREADYOUT = w_s_rdy; HRESP = w_s_resp; end
          DS_DBG: begin HRDATA = D_HRDATA; HREADYOUT = D_HREADYOUT; end
          default: ;
        endcase
      end
    endcase
  end

  // ---- data-phase register, response FSM, abandonment tracking ----
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_dsel     <= DS_NONE;
      r_dsel_idx <= '0;
      r_abn_vld  <= 1'b0;
      r_abn_idx  <= '0;
      r_to_slave <= '0;
    end else begin
      if (w_expire) begin
        r_state <= ST_ERR1;
        if (r_dsel == DS_DBG) begin
          r_to_slave <= 2'b11;
        end else begin
          r_to_slave <= r_dsel_idx;
          r_abn_vld  <= 1'b1;
          r_abn_idx  <= r_dsel_idx;
        end
      end else begin
        if (r_abn_vld && w_abn_rdy) r_abn_vld <= 1'b0;
        case (r_state)
          ST_ERR1: r_state <= ST_ERR2;
          default: begin
            if (HREADY)                 r_state <= nxt_state(w_valid ? w_tgt : DS_NONE);
            else if (r_state == ST_ERR2) r_state <= ST_IDLE;
          end
        endcase
      end
      if (HREADY) begin
        r_dsel     <= w_valid ? w_tgt : DS_NONE;
        r_dsel_idx <= w_slot;
      end
    end
  end

endmodule

// File: tb/tb_user_ahb_slave_mux.sv
// Directed bench: dut A (all slots, TIMEOUT=8) and dut B (slot 2 disabled,
// watchdog off) share the master/slave stimulus; use_b picks whose outputs
// close the HREADY loop and get checked.
module tb_user_ahb_slave_mux;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic         HSEL = 1'b0;
  logic [31:0]  HADDR = '0;
  logic [1:0]   HTRANS = 2'b00;
  logic         HWRITE = 1'b0;
  logic         HREADY;
  logic [127:0] S_HRDATA = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
  logic [3:0]   S_HREADYOUT = 4'b1111;
  logic [3:0]   S_HRESP = 4'b0000;
  logic [31:0]  D_HRDATA = 32'hDB60_0FFC;
  logic         D_HREADYOUT = 1'b1;
  logic         use_b = 1'b0;

  logic [31:0] a_rdata, b_rdata, o_rdata;
  logic        a_ready, b_ready, o_ready, a_resp, b_resp, o_resp;
  logic [3:0]  a_shsel, b_shsel, o_shsel;
  logic        a_dhsel, b_dhsel, o_dhsel, a_irq, b_irq, o_irq;
  logic [1:0]  a_to, b_to, o_to;

  always #5 HCLK = ~HCLK;

  assign o_rdata = use_b ? b_rdata : a_rdata;
  assign o_ready = use_b ? b_ready : a_ready;
  assign o_resp  = use_b ? b_resp  : a_resp;
  assign o_shsel = use_b ? b_shsel : a_shsel;
  assign o_dhsel = use_b ? b_dhsel : a_dhsel;
  assign o_irq   = use_b ? b_irq   : a_irq;
  assign o_to    = use_b ? b_to    : a_to;
  assign HREADY  = o_ready;

  user_ahb_slave_mux #(.NSLV(4), .SLV_EN(4'b1111), .TIMEOUT(8)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(a_rdata), .HREADYOUT(a_ready),
    .HRESP(a_resp), .S_HSEL(a_shsel), .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT),
    .S_HRESP(S_HRESP), .D_HSEL(a_dhsel), .D_HRDATA(D_HRDATA), .D_HREADYOUT(D_HREADYOUT),
    .timeout_irq(a_irq), .to_slave(a_to));

  user_ahb_slave_mux #(.NSLV(4), .SLV_EN(4'b1011), .TIMEOUT(0)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(b_rdata), .HREADYOUT(b_ready),
    .HRESP(b_resp), .S_HSEL(b_shsel), .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT),
    .S_HRESP(S_HRESP), .D_HSEL(b_dhsel), .D_HRDATA(D_HRDATA), .D_HREADYOUT(D_HREADYOUT),
    .timeout_irq(b_irq), .to_slave(b_to));

  typedef struct packed { logic [31:0] d; logic r; } exp_t;
  exp_t sb[$];
  int ntest = 0, nfail = 0;
  int irq_n, irq_at;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      ntest++; nfail++;
      $error("FAIL %s: scoreboard empty, got data %h", tag, o_rdata);
    end else begin
      e = sb.pop_front();
      chk({tag, ".data"}, o_rdata, e.d);
      chk({tag, ".resp"}, 32'(o_resp), 32'(e.r));
    end
  endtask

  task automatic idle(input int n);
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // One NONSEQ transfer; slot>=0 makes that slave hold ready low for 'waits' cycles.
  task automatic xfer(input string tag, input logic [31:0] addr, input int slot,
                      input int waits, input logic [31:0] ed, input logic er,
                      input logic [3:0] e_shsel, input logic e_dhsel, input int e_lat);
    bit done = 0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr;
    sb.push_back('{ed, er});
    #1;
    chk({tag, ".shsel"}, 32'(o_shsel), 32'(e_shsel));
    chk({tag, ".dhsel"}, 32'(o_dhsel), 32'(e_dhsel));
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    irq_n = 0; irq_at = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (slot >= 0) S_HREADYOUT[slot] = (c > waits);
      @(negedge HCLK);
      if (o_irq) begin irq_n++; irq_at = c; end
      if (o_ready) begin
        pop_chk(tag);
        chk({tag, ".lat"}, 32'(c), 32'(e_lat));
        done = 1;
      end
      @(posedge HCLK); #1;
    end
    if (!done) begin
      ntest++; nfail++;
      $error("FAIL %s.timeout: no HREADYOUT within 60 cycles, exp latency %0d", tag, e_lat);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.resp",  32'(o_resp),  32'd0);
    chk("rst.data",  o_rdata,      32'd0);
    chk("rst.irq",   32'(o_irq),   32'd0);
    chk("rst.to",    32'(o_to),    32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle(2);

    // mapped reads, debug window, wait states
    xfer("s2",   32'h3020_0010, 2, 0, 32'hA5A5_0002, 1'b0, 4'b0100, 1'b0, 1);
    xfer("dbg",  32'h30FF_FFFC, -1, 0, 32'hDB60_0FFC, 1'b0, 4'b0000, 1'b1, 1);
    xfer("s3w2", 32'h3030_0004, 3, 2, 32'hA5A5_0003, 1'b0, 4'b1000, 1'b0, 3);

    // watchdog expiry on slave 1: 9 low cycles (count 0..8), then ERR1, ERR2
    xfer("wd", 32'h3010_0000, 1, 100, 32'h0, 1'b1, 4'b0010, 1'b0, 11);
    chk("wd.irq_n",  32'(irq_n), 32'd1);
    chk("wd.irq_at", 32'(irq_at), 32'd10);
    chk("wd.to",     32'(o_to), 32'd1);
    // abandoned slot errors while slave 1 still not ready
    xfer("abn", 32'h3010_0000, -1, 0, 32'h0, 1'b1, 4'b0000, 1'b0, 2);
    S_HREADYOUT[1] = 1'b1;
    idle(1);
    xfer("abn.clr", 32'h3010_0008, 1, 0, 32'hA5A5_0001, 1'b0, 4'b0010, 1'b0, 1);

    // ready arrives in the exact cycle count==TIMEOUT: slave wins
    xfer("exact", 32'h3000_0000, 0, 8, 32'hA5A5_0000, 1'b0, 4'b0001, 1'b0, 9);
    chk("exact.irq_n", 32'(irq_n), 32'd0);
    chk("exact.to",    32'(o_to), 32'd1);

    // dut B: disabled slot 2 errors, next transfer accepted in ERR2
    use_b = 1'b1;
    idle(3);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h3020_0010;
    sb.push_back('{32'h0, 1'b1});
    #1;
    chk("b.err.shsel", 32'(o_shsel), 32'd0);
    @(posedge HCLK); #1;
    HADDR = 32'h3000_0040;
    sb.push_back('{32'hA5A5_0000, 1'b0});
    @(negedge HCLK);
    chk("b.err1.ready", 32'(o_ready), 32'd0);
    chk("b.err1.resp",  32'(o_resp),  32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("b.err2.ready", 32'(o_ready), 32'd1);
    pop_chk("b.err2");
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    chk("b.b2b.ready", 32'(o_ready), 32'd1);
    pop_chk("b.b2b");
    @(posedge HCLK); #1;
    // watchdog disabled: long wait completes normally
    xfer("b.nowd", 32'h3030_0000, 3, 20, 32'hA5A5_0003, 1'b0, 4'b1000, 1'b0, 21);
    chk("b.nowd.irq_n", 32'(irq_n), 32'd0);

    // dut A: reset in the middle of a wait
    use_b = 1'b0;
    idle(3);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h3000_0000;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    S_HREADYOUT[0] = 1'b0;
    @(negedge HCLK);
    chk("mid.wait.ready", 32'(o_ready), 32'd0);
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("mid.rst.ready", 32'(o_ready), 32'd1);
    chk("mid.rst.resp",  32'(o_resp),  32'd0);
    chk("mid.rst.data",  o_rdata,      32'd0);
    chk("mid.rst.irq",   32'(o_irq),   32'd0);
    chk("mid.rst.to",    32'(o_to),    32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    S_HREADYOUT[0] = 1'b1;
    @(posedge HCLK); #1;
    // IDLE transfer to slot 0 must leave dsel NONE (data stays 0)
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h3000_0000;
    sb.push_back('{32'h0, 1'b0});
    @(posedge HCLK); #1;
    HSEL = 1'b0;
    @(negedge HCLK);
    chk("idle.ready", 32'(o_ready), 32'd1);
    pop_chk("idle");
    chk("sb.left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, exp finish", $time);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/user_ahb_slave_mux.md
Name: user_ahb_slave_mux

Overview:
AHB-Lite decoder and multiplexer that shares the user-project AHB slave port between up to NSLV user slaves and the fixed debug-register slave.
- Registers the data-phase select.
- Muxes HRDATA/HREADYOUT/HRESP back to the master.
- Generates two-cycle ERROR responses for unmapped or disabled regions.
- Runs a wait-state watchdog that abandons hung slaves.
- Sits between the wrapper's AHB ports and the user/debug slaves; replaces ad-hoc HRDATA selection.

Parameters:
NSLV, 4, number of user slaves (1..4); slave i owns HADDR[21:20]==i
SLV_EN, 4'b1111, per-slot enable mask; disabled slot decodes to default (error) slave
TIMEOUT, 255, max wait cycles before watchdog error; 0 disables watchdog

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  master select for user area
HADDR  in  32  address
HTRANS  in  2  transfer type (only HTRANS[1] used)
HWRITE  in  1  direction (passed through by slaves; unused here)
HREADY  in  1  bus ready (address phase accepted when high)
HRDATA  out  32  muxed read data
HREADYOUT  out  1  muxed ready
HRESP  out  1  muxed response (1 = ERROR)
S_HSEL  out  NSLV  per-slave select (combinational)
S_HRDATA  in  32*NSLV  flattened slave read data, slave i at [32i+31:32i]
S_HREADYOUT  in  NSLV  slave ready
S_HRESP  in  NSLV  slave response
D_HSEL  out  1  debug-register select
D_HRDATA  in  32  debug read data
D_HREADYOUT  in  1  debug ready (debug never errors)
timeout_irq  out  1  one-cycle pulse on watchdog expiry
to_slave  out  2  index of last abandoned slave (sticky until next expiry)

Behaviour:
- Decode (combinational):
  - HADDR[23:3]==21'h1FFFFF → debug (covers offsets 0xFFFFF8/0xFFFFFC).
  - Else slot=HADDR[21:20]; slot<NSLV and SLV_EN[slot] and slot≠abandoned → S_HSEL[slot]=HSEL.
  - Else default slave.
  - D_HSEL / S_HSEL forced 0 when HSEL=0.
- Data-phase register dsel ∈ {NONE, SLV[i], DBG, DEF} updates only when HREADY=1.
  - Valid transfer (HSEL & HTRANS[1]) → decoded target.
  - Otherwise NONE.
- Output mux by dsel:
  - NONE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - SLV[i]: S_* of slave i.
  - DBG: D_HRDATA, D_HREADYOUT, HRESP=0.
- Response FSM states IDLE, ERR1, ERR2, WAIT:
  - DEF data phase → ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → IDLE, or WAIT if a new transfer is accepted in ERR2.
  - ERR2 accepts the next address phase like any ready cycle.
  - WAIT = slave data phase with HREADYOUT low; the watchdog runs here.
- Watchdog:
  - Counter width $clog2(TIMEOUT+1); increments each cycle dsel is SLV/DBG and the selected ready is 0; clears when ready=1.
  - Count==TIMEOUT with ready still 0:
    - Force ERR1/ERR2 to the master, overriding slave outputs.
    - Pulse timeout_irq in the ERR1 cycle.
    - Latch to_slave (DBG encodes as 2'b11 with no abandonment).
    - Set abandoned_vld for that slave.
  - Abandoned slave decodes to DEF until its S_HREADYOUT is seen high, then abandoned_vld clears.
  - TIMEOUT=0: counter held at 0, never expires.
- Simultaneous events: slave ready=1 in the same cycle the count reaches TIMEOUT → slave response wins, no error.
- Reset (async assert, sync-release usage assumed upstream):
  - FSM IDLE, dsel NONE, counter 0, abandoned_vld 0, to_slave 0, timeout_irq 0.
  - Outputs during reset: HREADYOUT=1, HRESP=0, HRDATA=0.
- Latency: zero added wait states for mapped slaves; unmapped access costs exactly 2 data-phase cycles.

Decomposition:
- Shared package user_ahb_pkg holds:
  - dsel encoding enum and FSM state enum.
  - DBG_WIN constant 21'h1FFFFF and slot field position 21:20.
  - HRESP_OKAY/HRESP_ERROR.
- One natural sub-module: ahb_wait_watchdog (counter, expiry compare, irq pulse); decode, mux and FSM stay in the top.

Test Plan:
- Read slot 2 (HADDR=0x3020_0010), slave 2 returns 0xA5A5_0002 with 0 waits → HRDATA=0xA5A5_0002, HREADYOUT=1, HRESP=0 next cycle; no other S_HSEL asserted.
- Read 0x30FF_FFFC → D_HSEL=1 in address phase; HRDATA=D_HRDATA; S_HSEL=0.
- SLV_EN=4'b1011, access slot 2 → ERR1 (ready 0, resp 1) then ERR2 (ready 1, resp 1); back-to-back valid transfer in ERR2 is accepted.
- TIMEOUT=8, slave 1 holds ready low → ERROR after 8 wait cycles, timeout_irq high exactly 1 cycle, to_slave=1; next slot-1 access errors until slave 1 raises ready, then succeeds.
- Slave 0 raises ready on the exact expiry cycle → OKAY response, no irq.
- HRESETn low mid-WAIT → outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0, timeout_irq=0; after release an IDLE transfer keeps dsel NONE.
